// File: rtl/ysyx_22050368_exu_ctrl_pkg.sv
// Shared encodings for the execute-stage sequencer: hold levels, FSM states and a
// saturating-increment helper.
package ysyx_22050368_exu_ctrl_pkg;

   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_IF   = 3'd2;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   typedef enum logic [1:0] {
      ExcIdle,
      ExcIssue,
      ExcWait,
      ExcFlush
   } exc_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ysyx_22050368_hazard.sv
// Load-use hazard detect: an EX load whose destination feeds an ID source operand.
// Purely combinational; x0 is never a real dependency.
module ysyx_22050368_hazard (
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd_idx,
   input  logic [4:0] id_rs1_idx,
   input  logic [4:0] id_rs2_idx,
   output logic       load_use
);

   assign load_use = ex_valid & ex_is_load & (ex_rd_idx != 5'd0) &
                     ((ex_rd_idx == id_rs1_idx) | (ex_rd_idx == id_rs2_idx));

endmodule

// File: rtl/ysyx_22050368_exu_ctrl.sv
// Execute-stage sequencer: issues multi-cycle MDU ops, drives the pipeline hold level and
// converts a taken EXU jump into a registered one-cycle redirect plus IF/ID flush.
module ysyx_22050368_exu_ctrl
   import ysyx_22050368_exu_ctrl_pkg::*;
#(
   parameter int unsigned MDU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_is_mdu,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd_idx,
   input  logic [4:0]  id_rs1_idx,
   input  logic [4:0]  id_rs2_idx,
   input  logic        jump_flag,
   input  logic [63:0] jump_addr,
   input  logic        mdu_ready,
   input  logic        mdu_done,
   output logic        mdu_start,
   output logic        mdu_abort,
   output logic [2:0]  hold_flag_o,
   output logic        redirect_vld,
   output logic [63:0] redirect_addr,
   output logic        flush_o,
   output logic        mdu_err,
   output logic [31:0] stall_cnt
);

   exc_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [63:0]       redirect_addr_q;
   logic              redirect_vld_q;
   logic              flush_q;
   logic [31:0]       stall_cnt_q;

   logic load_use;
   logic take_jump;
   logic take_mdu;
   logic timeout;

   ysyx_22050368_hazard u_hazard (
      .ex_valid   (ex_valid),
      .ex_is_load (ex_is_load),
      .ex_rd_idx  (ex_rd_idx),
      .id_rs1_idx (id_rs1_idx),
      .id_rs2_idx (id_rs2_idx),
      .load_use   (load_use)
   );

   // Jump outranks an MDU op presented in the same cycle.
   assign take_jump = (state_q == ExcIdle) & ex_valid & jump_flag;
   assign take_mdu  = (state_q == ExcIdle) & ex_valid & ex_is_mdu & ~jump_flag;

   // A done arriving on the last allowed cycle still completes the op normally.
   assign timeout = (state_q == ExcWait) & ~mdu_done &
                    (cnt_q == CNT_W'(MDU_TIMEOUT - 1));

   assign mdu_start     = (state_q == ExcIssue) & mdu_ready;
   assign mdu_abort     = timeout;
   assign mdu_err       = timeout;
   assign redirect_vld  = redirect_vld_q;
   assign redirect_addr = redirect_addr_q;
   assign flush_o       = flush_q;
   assign stall_cnt     = stall_cnt_q;

   always_comb begin
      hold_flag_o = HOLD_NONE;
      unique case (state_q)
         ExcIdle: begin
            if (take_jump) begin
               hold_flag_o = HOLD_NONE;
            end else if (take_mdu) begin
               hold_flag_o = HOLD_ID;
            end else if (load_use) begin
               hold_flag_o = HOLD_IF;
            end
         end
         ExcIssue: hold_flag_o = HOLD_ID;
         ExcWait:  hold_flag_o = mdu_done ? HOLD_NONE : HOLD_ID;
         ExcFlush: hold_flag_o = HOLD_NONE;
         default:  hold_flag_o = HOLD_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ExcIdle;
         cnt_q           <= '0;
         redirect_addr_q <= '0;
         redirect_vld_q  <= 1'b0;
         flush_q         <= 1'b0;
         stall_cnt_q     <= '0;
      end else begin
         redirect_vld_q <= take_jump;
         flush_q        <= take_jump;
         if (take_jump) begin
            redirect_addr_q <= jump_addr;
         end
         if (hold_flag_o != HOLD_NONE) begin
            stall_cnt_q <= sat_inc32(stall_cnt_q);
         end
         unique case (state_q)
            ExcIdle: begin
               if (take_jump) begin
                  state_q <= ExcFlush;
               end else if (take_mdu) begin
                  state_q <= ExcIssue;
               end
            end
            ExcIssue: begin
               if (mdu_ready) begin
                  state_q <= ExcWait;
                  cnt_q   <= '0;
               end
            end
            ExcWait: begin
               if (mdu_done || timeout) begin
                  state_q <= ExcIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ExcFlush: state_q <= ExcIdle;
            default:  state_q <= ExcIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050368_exu_ctrl.sv
// Bench for the execute-stage sequencer: directed scenarios plus random traffic, each
// cycle's expected outputs queued by a behavioural model and checked by a monitor.
module tb_ysyx_22050368_exu_ctrl;

   localparam int unsigned T = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_is_mdu = 1'b0, ex_is_load = 1'b0;
   logic [4:0]  ex_rd_idx = '0, id_rs1_idx = '0, id_rs2_idx = '0;
   logic        jump_flag = 1'b0;
   logic [63:0] jump_addr = '0;
   logic        mdu_ready = 1'b0, mdu_done = 1'b0;
   logic        mdu_start, mdu_abort, redirect_vld, flush_o, mdu_err;
   logic [2:0]  hold_flag_o;
   logic [63:0] redirect_addr;
   logic [31:0] stall_cnt;

   ysyx_22050368_exu_ctrl #(
      .MDU_TIMEOUT (T),
      .CNT_W       (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_is_mdu     (ex_is_mdu),
      .ex_is_load    (ex_is_load),
      .ex_rd_idx     (ex_rd_idx),
      .id_rs1_idx    (id_rs1_idx),
      .id_rs2_idx    (id_rs2_idx),
      .jump_flag     (jump_flag),
      .jump_addr     (jump_addr),
      .mdu_ready     (mdu_ready),
      .mdu_done      (mdu_done),
      .mdu_start     (mdu_start),
      .mdu_abort     (mdu_abort),
      .hold_flag_o   (hold_flag_o),
      .redirect_vld  (redirect_vld),
      .redirect_addr (redirect_addr),
      .flush_o       (flush_o),
      .mdu_err       (mdu_err),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        start;
      logic        abort;
      logic [2:0]  hold;
      logic        rv;
      logic        chk_ra;
      logic [63:0] ra;
      logic        fl;
      logic        err;
      logic [31:0] stall;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: an op either awaits MDU acceptance or has been running for op_age cycles;
   // a taken jump schedules a redirect for the following cycle.
   bit          await_ready = 0;
   bit          running     = 0;
   int          op_age      = 0;
   bit          redir_due   = 0;
   logic [63:0] redir_target = '0;
   logic [31:0] stall_m     = '0;

   task automatic predict();
      exp_t e;
      e = '0;
      if (!rst_n) begin
         await_ready = 0;
         running     = 0;
         op_age      = 0;
         redir_due   = 0;
         stall_m     = '0;
         e.chk_ra    = 1'b1;
         sb_q.push_back(e);
         return;
      end
      e.stall = stall_m;
      if (redir_due) begin
         e.rv      = 1'b1;
         e.chk_ra  = 1'b1;
         e.ra      = redir_target;
         e.fl      = 1'b1;
         redir_due = 0;
      end else if (await_ready) begin
         e.hold  = 3'd3;
         e.start = mdu_ready;
         if (mdu_ready) begin
            await_ready = 0;
            running     = 1;
            op_age      = 0;
         end
      end else if (running) begin
         if (mdu_done) begin
            running = 0;
         end else if (op_age == int'(T) - 1) begin
            e.hold  = 3'd3;
            e.abort = 1'b1;
            e.err   = 1'b1;
            running = 0;
         end else begin
            e.hold = 3'd3;
            op_age++;
         end
      end else if (ex_valid && jump_flag) begin
         redir_due    = 1;
         redir_target = jump_addr;
      end else if (ex_valid && ex_is_mdu) begin
         e.hold      = 3'd3;
         await_ready = 1;
      end else if (ex_valid && ex_is_load && ex_rd_idx != 0 &&
                   (ex_rd_idx == id_rs1_idx || ex_rd_idx == id_rs2_idx)) begin
         e.hold = 3'd2;
      end
      if (e.hold != 0 && stall_m != 32'hFFFF_FFFF) stall_m++;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic mdu, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic jf,
                        input logic [63:0] ja, input logic rdy, input logic dn);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ex_valid   = v;
      ex_is_mdu  = mdu;
      ex_is_load = ld;
      ex_rd_idx  = rd;
      id_rs1_idx = rs1;
      id_rs2_idx = rs2;
      jump_flag  = jf;
      jump_addr  = ja;
      mdu_ready  = rdy;
      mdu_done   = dn;
      predict();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n      = 1'b0;
         ex_valid   = 0; ex_is_mdu = 0; ex_is_load = 0;
         ex_rd_idx  = 0; id_rs1_idx = 0; id_rs2_idx = 0;
         jump_flag  = 0; jump_addr = 0; mdu_ready = 0; mdu_done = 0;
         predict();
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("mdu_start", 64'(mdu_start), 64'(e.start));
         chk("mdu_abort", 64'(mdu_abort), 64'(e.abort));
         chk("hold_flag", 64'(hold_flag_o), 64'(e.hold));
         chk("redirect_vld", 64'(redirect_vld), 64'(e.rv));
         if (e.chk_ra) chk("redirect_addr", redirect_addr, e.ra);
         chk("flush", 64'(flush_o), 64'(e.fl));
         chk("mdu_err", 64'(mdu_err), 64'(e.err));
         chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
      end
   end

   initial begin
      // Reset and timeout with no done: hold 3 for 10 cycles.
      do_reset(3);
      idle(2);
      drive(1, 1, 0, 5'd3, 0, 0, 0, 64'd0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
      for (int i = 0; i < int'(T); i++) drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      idle(2);
      // MDU op: ready at t1, done at t5.
      drive(1, 1, 0, 5'd4, 0, 0, 0, 64'd0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
      idle(3);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1);
      idle(1);
      // Jump redirect one cycle later.
      drive(1, 0, 0, 0, 0, 0, 1, 64'h8000_0100, 0, 0);
      idle(2);
      // Load-use with rd=5 then rd=0.
      drive(1, 0, 1, 5'd5, 5'd1, 5'd5, 0, 64'd0, 0, 0);
      drive(1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 64'd0, 0, 0);
      idle(1);
      // ISSUE with ready low for 4 cycles.
      drive(1, 1, 0, 5'd2, 0, 0, 0, 64'd0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
      idle(2);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 1);
      // Done arriving while idle is ignored; mdu_done on the timeout cycle completes.
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1);
      drive(1, 1, 0, 5'd2, 0, 0, 0, 64'd0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
      for (int i = 0; i < int'(T) - 1; i++) drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1);
      // Reset mid-WAIT.
      drive(1, 1, 0, 5'd2, 0, 0, 0, 64'd0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
      idle(3);
      do_reset(3);
      idle(1);
      // Random traffic with one reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         logic mdu;
         logic [63:0] ja;
         if (i == 1500) do_reset(3);
         mdu = ($urandom % 8) == 0;
         ja  = {$urandom, $urandom};
         drive(($urandom % 4) != 0, mdu, ($urandom % 4) == 0, 5'($urandom % 4),
               5'($urandom % 4), 5'($urandom % 4), !mdu && (($urandom % 10) == 0), ja,
               ($urandom % 3) != 0, ($urandom % 12) == 0);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
